// File: rtl/clk_div_multi.sv
// -----------------------------------------------------------------------------
// clk_div_multi
//
// Multi-channel programmable tick / square-wave generator. Each channel has one
// counter running 0..D-1 in the clk domain; at the wrap it emits a one-cycle
// tick and toggles a 50 % duty fout. No derived clocks are produced.
//
// Divisor loads are normally deferred: the new value is parked in a per-channel
// shadow register and applied at the channel's next wrap, so the output period
// changes without glitches. Define CLKDIV_IMMEDIATE_LOAD_EN to make loads take
// effect on the accepting edge instead (counter restarts, no shadow/pending).
//
// Ports:
//   clk       in   1          global clock, rising edge
//   rst_n     in   1          asynchronous active-low reset
//   en        in   NCH        per-channel run enable
//   ld_valid  in   1          divisor load request
//   ld_ch     in   LW         target channel of the load (>= NCH is discarded)
//   ld_div    in   CW         new divisor D (0 halts the channel)
//   ld_ready  out  1          load can be accepted this cycle (combinational)
//   tick      out  NCH        one-cycle strobe per channel, registered
//   fout      out  NCH        divided square wave per channel, registered
// -----------------------------------------------------------------------------
module clk_div_multi #(
    parameter  int unsigned NCH      = 4,
    parameter  int unsigned CW       = 27,
    parameter  int unsigned DIV_INIT = 50_000_000,
    localparam int unsigned LW       = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [NCH-1:0] en,
    input  logic           ld_valid,
    input  logic [LW-1:0]  ld_ch,
    input  logic [CW-1:0]  ld_div,
    output logic           ld_ready,
    output logic [NCH-1:0] tick,
    output logic [NCH-1:0] fout
);

    logic           ch_ok;
    logic [NCH-1:0] ld_sel;

    always_comb begin
        ch_ok = (32'(ld_ch) < NCH);
    end

`ifndef CLKDIV_IMMEDIATE_LOAD_EN
    logic [NCH-1:0] pend;

    // Out-of-range channels are always ready so the request is swallowed.
    always_comb begin
        ld_ready = 1'b1;
        if (ch_ok) begin
            ld_ready = !pend[ld_ch];
        end
    end
`else
    always_comb begin
        ld_ready = 1'b1;
    end
`endif

    always_comb begin
        ld_sel = '0;
        for (int unsigned c = 0; c < NCH; c++) begin
            ld_sel[c] = ld_valid && ld_ready && ch_ok && (32'(ld_ch) == c);
        end
    end

    for (genvar g = 0; g < NCH; g++) begin : g_ch
        logic [CW-1:0] cnt;
        logic [CW-1:0] div_q;
        logic          tick_q;
        logic          fout_q;
        logic          run;
        logic          wrap;

        always_comb begin
            run  = en[g] && (div_q != '0);
            wrap = run && (cnt == div_q - CW'(1));
        end

`ifndef CLKDIV_IMMEDIATE_LOAD_EN
        logic [CW-1:0] shd;
        logic          pend_q;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                cnt    <= '0;
                div_q  <= CW'(DIV_INIT);
                shd    <= '0;
                pend_q <= 1'b0;
                tick_q <= 1'b0;
                fout_q <= 1'b0;
            end else begin
                tick_q <= 1'b0;
                if (!run) begin
                    // A stopped channel has no wrap to wait for, so a pending
                    // divisor is taken over at once and the count restarts.
                    if (pend_q) begin
                        div_q  <= shd;
                        pend_q <= 1'b0;
                        cnt    <= '0;
                    end else if (div_q == '0) begin
                        cnt <= '0;
                    end
                end else if (wrap) begin
                    cnt    <= '0;
                    tick_q <= 1'b1;
                    fout_q <= !fout_q;
                    if (pend_q) begin
                        div_q  <= shd;
                        pend_q <= 1'b0;
                    end
                end else begin
                    cnt <= cnt + CW'(1);
                end
                // ld_sel implies pend_q was clear, so this never collides
                // with the apply paths above.
                if (ld_sel[g]) begin
                    shd    <= ld_div;
                    pend_q <= 1'b1;
                end
            end
        end

        always_comb begin
            pend[g] = pend_q;
        end
`else
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                cnt    <= '0;
                div_q  <= CW'(DIV_INIT);
                tick_q <= 1'b0;
                fout_q <= 1'b0;
            end else begin
                tick_q <= 1'b0;
                if (ld_sel[g]) begin
                    div_q <= ld_div;
                    cnt   <= '0;
                end else if (!run) begin
                    if (div_q == '0) begin
                        cnt <= '0;
                    end
                end else if (wrap) begin
                    cnt    <= '0;
                    tick_q <= 1'b1;
                    fout_q <= !fout_q;
                end else begin
                    cnt <= cnt + CW'(1);
                end
            end
        end
`endif

        always_comb begin
            tick[g] = tick_q;
            fout[g] = fout_q;
        end
    end

endmodule

// File: tb/tb_clk_div_multi.sv
// -----------------------------------------------------------------------------
// tb_clk_div_multi
//
// Scoreboard bench for clk_div_multi (NCH=5, CW=8, DIV_INIT=5). A reference
// model tracks, per channel, how many enabled cycles remain until the next
// tick, plus the active/pending divisor. Each cycle the model pushes the
// expected tick/fout/ld_ready into a queue; a separate monitor pops and
// compares against the DUT. Directed steps cover the reset, load, pending,
// disable, halt and out-of-range cases, followed by randomized traffic.
// Honours CLKDIV_IMMEDIATE_LOAD_EN in its model.
// -----------------------------------------------------------------------------
module tb_clk_div_multi;

    localparam int unsigned NCH      = 5;
    localparam int unsigned CW       = 8;
    localparam int unsigned DIV_INIT = 5;
    localparam int unsigned LW       = 3;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [NCH-1:0] en;
    logic           ld_valid;
    logic [LW-1:0]  ld_ch;
    logic [CW-1:0]  ld_div;
    logic           ld_ready;
    logic [NCH-1:0] tick;
    logic [NCH-1:0] fout;

    always #5 clk = ~clk;

    clk_div_multi #(
        .NCH      (NCH),
        .CW       (CW),
        .DIV_INIT (DIV_INIT)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .ld_valid (ld_valid),
        .ld_ch    (ld_ch),
        .ld_div   (ld_div),
        .ld_ready (ld_ready),
        .tick     (tick),
        .fout     (fout)
    );

    typedef struct packed {
        logic [NCH-1:0] tk;
        logic [NCH-1:0] fo;
        logic           rdy;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model state
    int m_left [NCH];   // enabled cycles until next tick
    int m_dv   [NCH];   // active divisor
    int m_nxt  [NCH];   // deferred divisor
    bit m_pend [NCH];
    bit m_tk   [NCH];
    bit m_fo   [NCH];

    function automatic void m_reset();
        for (int c = 0; c < NCH; c++) begin
            m_left[c] = DIV_INIT;
            m_dv[c]   = DIV_INIT;
            m_nxt[c]  = 0;
            m_pend[c] = 1'b0;
            m_tk[c]   = 1'b0;
            m_fo[c]   = 1'b0;
        end
    endfunction

    function automatic bit m_ready();
        int ch = int'(ld_ch);
        if (ch >= NCH) return 1'b1;
`ifdef CLKDIV_IMMEDIATE_LOAD_EN
        return 1'b1;
`else
        return !m_pend[ch];
`endif
    endfunction

    function automatic void m_edge();
        bit acc = ld_valid && m_ready();
        int ch  = int'(ld_ch);
        for (int c = 0; c < NCH; c++) begin
            bit run = en[c] && (m_dv[c] != 0);
`ifdef CLKDIV_IMMEDIATE_LOAD_EN
            if (acc && ch == c) begin
                m_dv[c]   = int'(ld_div);
                m_left[c] = m_dv[c];
                m_tk[c]   = 1'b0;
                continue;
            end
`endif
            m_tk[c] = 1'b0;
            if (!run) begin
                if (m_pend[c]) begin
                    m_dv[c]   = m_nxt[c];
                    m_pend[c] = 1'b0;
                    m_left[c] = m_dv[c];
                end
            end else begin
                m_left[c] = m_left[c] - 1;
                if (m_left[c] == 0) begin
                    m_tk[c] = 1'b1;
                    m_fo[c] = !m_fo[c];
                    if (m_pend[c]) begin
                        m_dv[c]   = m_nxt[c];
                        m_pend[c] = 1'b0;
                    end
                    m_left[c] = m_dv[c];
                end
            end
        end
`ifndef CLKDIV_IMMEDIATE_LOAD_EN
        if (acc && ch < NCH) begin
            m_nxt[ch]  = int'(ld_div);
            m_pend[ch] = 1'b1;
        end
`endif
    endfunction

    // Model: inputs are stable from negedge until the next posedge, so the
    // prediction for the coming edge is made mid-cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (!rst_n) m_reset();
            e.rdy = m_ready();
            for (int c = 0; c < NCH; c++) begin
                e.tk[c] = m_tk[c];
                e.fo[c] = m_fo[c];
            end
            exp_q.push_back(e);
            if (rst_n) m_edge();
        end
    end

    function automatic void chk(string name, int act, int expv);
        checks++;
        if (act != expv) begin
            errors++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, expv);
        end
    endfunction

    // Monitor
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #3;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_empty at %0t: got no expectation, expected one", $time);
            end else begin
                e = exp_q.pop_front();
                chk("tick", int'(tick), int'(e.tk));
                chk("fout", int'(fout), int'(e.fo));
                chk("ld_ready", int'(ld_ready), int'(e.rdy));
            end
        end
    end

    // Called at a negedge; returns at a negedge with ld_valid dropped after
    // the accepting edge.
    task automatic load(input int ch, input int d);
        bit got = 1'b0;
        ld_valid = 1'b1;
        ld_ch    = LW'(ch);
        ld_div   = CW'(d);
        for (int i = 0; i < 40; i++) begin
            #1;
            if (ld_ready) begin
                got = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL load_timeout ch%0d: ld_ready stayed 0, expected 1 within 40 cycles", ch);
        end
        @(negedge clk);
        ld_valid = 1'b0;
    endtask

    initial begin
        rst_n    = 1'b0;
        en       = '1;
        ld_valid = 1'b0;
        ld_ch    = '0;
        ld_div   = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (12) @(negedge clk);

        // Deferred load, then a second one that must wait for the pend flag.
        load(2, 3);
        load(2, 7);
        repeat (20) @(negedge clk);

        // Disable channel 1 for 7 cycles.
        en[1] = 1'b0;
        repeat (7) @(negedge clk);
        en[1] = 1'b1;
        repeat (12) @(negedge clk);

        // Halt channel 0, then revive it with D=1.
        load(0, 0);
        repeat (15) @(negedge clk);
        load(0, 1);
        repeat (6) @(negedge clk);

        // Out-of-range channel: accepted and discarded.
        load(6, 9);
        repeat (3) @(negedge clk);

        // Pending load lost to an asynchronous mid-cycle reset.
        load(3, 2);
        #1 rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);

        // Randomized traffic.
        for (int i = 0; i < 2000; i++) begin
            for (int c = 0; c < NCH; c++) en[c] = ($urandom_range(0, 15) != 0);
            ld_valid = ($urandom_range(0, 3) == 0);
            ld_ch    = LW'($urandom_range(0, 7));
            ld_div   = CW'($urandom_range(0, 7));
            if ($urandom_range(0, 399) == 0) begin
                #1 rst_n = 1'b0;
                @(negedge clk);
                rst_n = 1'b1;
            end else begin
                @(negedge clk);
            end
        end
        ld_valid = 1'b0;
        repeat (2) @(negedge clk);
        #4;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
